// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA read engine.
package dma_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam int         MAX_BURST   = 16;
    localparam int         BOUNDARY_4K = 4096;
    localparam int         BEAT_BYTES  = 4;
endpackage

// File: rtl/dma_burst_calc.sv
// Next burst size: min(remaining beats, MAX_BURST, beats left in the current 4 KB page).
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST = dma_pkg::MAX_BURST
) (
    input  logic [9:0]  page_offset,
    input  logic [31:0] remaining,
    output logic [8:0]  beats,
    output logic [7:0]  arlen
);
    localparam int PAGE_BEATS = BOUNDARY_4K / BEAT_BYTES;

    logic [10:0] to_boundary;
    logic [31:0] lim;

    always_comb begin
        to_boundary = 11'(PAGE_BEATS) - {1'b0, page_offset};
        lim = remaining;
        if (lim > 32'(MAX_BURST)) begin
            lim = 32'(MAX_BURST);
        end
        if (lim > {21'd0, to_boundary}) begin
            lim = {21'd0, to_boundary};
        end
        beats = 9'(lim);
        // Meaningless when remaining is zero; the top only drives it in the AR state.
        arlen = 8'(lim - 32'd1);
    end
endmodule

// File: rtl/dma_rd_engine.sv
// AXI4 read master: fetches i_len bytes from i_base_addr in INCR bursts and streams words out over AXI-Stream.
module dma_rd_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = dma_pkg::MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never waits on ready, and payload stays stable while valid is high and ready is low.
    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [31:0]             remaining;
    logic [8:0]              burst_beats;
    logic [8:0]              beat_cnt;
    logic                    done, error;
    logic [8:0]              calc_beats;
    logic [7:0]              calc_arlen;
    logic                    len_misaligned, len_zero;
    logic                    beat_last, beat_err, final_beat, r_good;

    dma_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
        .page_offset (addr[11:2]),
        .remaining   (remaining),
        .beats       (calc_beats),
        .arlen       (calc_arlen)
    );

    assign len_misaligned = (i_len[1:0] != 2'b00);
    assign len_zero       = (i_len == 32'd0);
    assign beat_last      = (beat_cnt == burst_beats - 9'd1);
    assign final_beat     = beat_last && (remaining == 32'd0);
    // Bad response or rlast disagreeing with our beat count poisons the rest of the burst.
    assign beat_err       = m_axi_rvalid && ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != beat_last));
    assign r_good         = m_axi_rvalid && m_axis_tready && !beat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start && !len_misaligned && !len_zero) begin
                    state_next = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                if (beat_err) begin
                    state_next = ST_DRAIN;
                end else if (r_good && beat_last) begin
                    state_next = (remaining == 32'd0) ? ST_IDLE : ST_AR;
                end
            end
            ST_DRAIN: begin
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            remaining   <= '0;
            burst_beats <= '0;
            beat_cnt    <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr      <= i_base_addr;
                        remaining <= {2'b00, i_len[31:2]};
                        done      <= len_misaligned || len_zero;
                        error     <= len_misaligned;
                    end
                end
                ST_AR: begin
                    if (m_axi_arready) begin
                        addr        <= addr + ADDR_WIDTH'({calc_beats, 2'b00});
                        remaining   <= remaining - 32'(calc_beats);
                        burst_beats <= calc_beats;
                        beat_cnt    <= '0;
                    end
                end
                ST_R: begin
                    if (beat_err) begin
                        error <= 1'b1;
                    end else if (r_good) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (final_beat) begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_axi_rvalid && m_axi_rlast) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy        = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_rready  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_AR: begin
                o_busy        = 1'b1;
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = addr;
                m_axi_arlen   = calc_arlen;
            end
            ST_R: begin
                // The faulty beat is held back here and swallowed by DRAIN on the next cycle.
                o_busy        = 1'b1;
                m_axi_rready  = m_axis_tready && !beat_err;
                m_axis_tvalid = m_axi_rvalid && !beat_err;
                m_axis_tdata  = m_axi_rdata;
                m_axis_tlast  = m_axi_rvalid && !beat_err && final_beat;
            end
            ST_DRAIN: begin
                o_busy       = 1'b1;
                m_axi_rready = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_done        = done;
    assign o_error       = error;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine with an AXI slave model and a queued stream/AR scoreboard.
module tb_dma_rd_engine;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [31:0] i_len = '0;
    logic        o_busy, o_done, o_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;

    always #5 clk = ~clk;

    dma_rd_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_len         (i_len),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] exp_q[$];     // {tlast, tdata}
    logic [39:0] ar_exp_q[$];  // {araddr, arlen}
    logic [39:0] burst_q[$];   // bursts accepted by the slave model

    logic        slv_active = 1'b0;
    logic [31:0] slv_addr = '0;
    int          slv_left = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        toggle_mode = 1'b0;
    int          tog_idx = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], 16'hA5C3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- clock/reset watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- AXI slave model + tready driver ----------------
    initial begin : slave
        logic        ar_hs, r_hs;
        logic [39:0] ar_req;
        logic [39:0] b;
        forever begin
            @(negedge clk);
            ar_hs  = m_axi_arvalid && m_axi_arready;
            r_hs   = m_axi_rvalid && m_axi_rready;
            ar_req = {m_axi_araddr, m_axi_arlen};
            @(posedge clk);
            #1;
            if (!rst_n) begin
                burst_q.delete();
                slv_active = 1'b0;
            end else begin
                if (ar_hs) burst_q.push_back(ar_req);
                if (r_hs && slv_active) begin
                    slv_addr = slv_addr + 32'd4;
                    slv_left--;
                    if (slv_left == 0) slv_active = 1'b0;
                end
                if (!slv_active && burst_q.size() > 0) begin
                    b = burst_q.pop_front();
                    slv_addr = b[39:8];
                    slv_left = int'(b[7:0]) + 1;
                    slv_active = 1'b1;
                end
            end
            m_axi_rvalid = slv_active;
            m_axi_rdata  = slv_active ? mem_word(slv_addr) : 32'd0;
            m_axi_rlast  = slv_active && (slv_left == 1);
            m_axi_rresp  = (slv_active && err_en && slv_addr == err_addr) ? 2'b10 : 2'b00;
            if (toggle_mode) begin
                m_axis_tready = !((tog_idx % 4 == 1) || (tog_idx % 4 == 2));
                tog_idx++;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        logic [40:0] exp_ar;
        logic [33:0] exp_s;
        if (rst_n) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_exp_q.size() != 0) exp_ar = {1'b1, ar_exp_q.pop_front()};
                else exp_ar = '0;
                check("ar_req", {23'd0, 1'b1, m_axi_araddr, m_axi_arlen}, {23'd0, exp_ar});
                check("ar_const", {59'd0, m_axi_arsize, m_axi_arburst}, {59'd0, SIZE_4B, BURST_INCR});
            end
            if (m_axis_tvalid) begin
                check("rready_tracks", {63'd0, m_axi_rready}, {63'd0, m_axis_tready});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() != 0) exp_s = {1'b1, exp_q.pop_front()};
                else exp_s = '0;
                check("stream_word", {30'd0, 1'b1, m_axis_tlast, m_axis_tdata}, {30'd0, exp_s});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start(input logic [31:0] base, input logic [31:0] len);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_base_addr = base;
        i_len = len;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), mem_word(base + 32'(4 * i))});
        end
    endtask

    task automatic wait_idle(input string name, input logic exp_err);
        int cyc = 0;
        while (!(!o_busy && o_done) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_timeout"}, 64'(cyc < 2000), 64'd1);
        check({name, "_status"}, {61'd0, o_busy, o_done, o_error}, {61'd0, 1'b0, 1'b1, exp_err});
        check({name, "_stream_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_ar_left"}, 64'(ar_exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ar"}, {22'd0, m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready}, 64'd0);
        check({name, "_stream"}, {26'd0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_error}, 64'd0);
        check({name, "_const"}, {59'd0, m_axi_arsize, m_axi_arburst}, {59'd0, 3'b010, 2'b01});
    endtask

    // ---------------- directed tests ----------------
    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single full burst.
        ar_exp_q.push_back({32'h0000_1000, 8'd15});
        push_words(32'h0000_1000, 16);
        start(32'h0000_1000, 32'd64);
        @(negedge clk);
        check("t1_arvalid_latency", {63'd0, m_axi_arvalid}, 64'd1);
        wait_idle("t1", 1'b0);

        // Multi-burst with a short tail.
        ar_exp_q.push_back({32'h0000_2000, 8'd15});
        ar_exp_q.push_back({32'h0000_2040, 8'd15});
        ar_exp_q.push_back({32'h0000_2080, 8'd15});
        ar_exp_q.push_back({32'h0000_20C0, 8'd1});
        push_words(32'h0000_2000, 50);
        start(32'h0000_2000, 32'd200);
        wait_idle("t2", 1'b0);

        // Ends exactly on a 4 KB boundary.
        ar_exp_q.push_back({32'h0000_0FC0, 8'd15});
        ar_exp_q.push_back({32'h0000_1000, 8'd15});
        push_words(32'h0000_0FC0, 32);
        start(32'h0000_0FC0, 32'd128);
        wait_idle("t3", 1'b0);

        // Would cross a 4 KB boundary: split at 0x2000.
        ar_exp_q.push_back({32'h0000_1FF0, 8'd3});
        ar_exp_q.push_back({32'h0000_2000, 8'd11});
        push_words(32'h0000_1FF0, 16);
        start(32'h0000_1FF0, 32'd64);
        wait_idle("t3b", 1'b0);

        // Zero and misaligned lengths.
        start(32'h0000_3000, 32'd0);
        @(negedge clk);
        check("t4_len0", {60'd0, o_busy, o_done, o_error, m_axi_arvalid}, {60'd0, 4'b0100});
        repeat (3) @(negedge clk);
        start(32'h0000_3000, 32'd6);
        @(negedge clk);
        check("t4_len6", {60'd0, o_busy, o_done, o_error, m_axi_arvalid}, {60'd0, 4'b0110});
        repeat (3) @(negedge clk);

        // SLVERR on beat 3: beats 1-2 forwarded, rest drained.
        err_en = 1'b1;
        err_addr = 32'h0000_3008;
        ar_exp_q.push_back({32'h0000_3000, 8'd15});
        exp_q.push_back({1'b0, mem_word(32'h0000_3000)});
        exp_q.push_back({1'b0, mem_word(32'h0000_3004)});
        start(32'h0000_3000, 32'd64);
        wait_idle("t5", 1'b1);
        err_en = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_extra_ar", 64'(ar_exp_q.size()), 64'd0);

        ar_exp_q.push_back({32'h0000_5000, 8'd3});
        push_words(32'h0000_5000, 4);
        start(32'h0000_5000, 32'd16);
        @(negedge clk);
        check("t5_clear", {62'd0, o_done, o_error}, 64'd0);
        wait_idle("t5b", 1'b0);

        // Backpressure pattern plus an ignored start mid-transfer.
        toggle_mode = 1'b1;
        tog_idx = 0;
        ar_exp_q.push_back({32'h0000_4000, 8'd15});
        ar_exp_q.push_back({32'h0000_4040, 8'd15});
        push_words(32'h0000_4000, 32);
        start(32'h0000_4000, 32'd128);
        repeat (10) @(posedge clk);
        start(32'h0000_8000, 32'd64);
        wait_idle("t6", 1'b0);
        toggle_mode = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_ignored_start", {63'd0, o_busy}, 64'd0);

        // Asynchronous reset in the middle of a burst.
        ar_exp_q.push_back({32'h0000_6000, 8'd15});
        push_words(32'h0000_6000, 16);
        start(32'h0000_6000, 32'd64);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t7_midreset");
        exp_q.delete();
        ar_exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_after_reset", {61'd0, o_busy, o_done, o_error, m_axi_arvalid}, 64'd0);

        ar_exp_q.push_back({32'h0000_7000, 8'd3});
        push_words(32'h0000_7000, 4);
        start(32'h0000_7000, 32'd16);
        wait_idle("t7_recover", 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
